mem_access_unit: RTL
====================

# mem_access_unit

Memory access stage of the multicycle MIPS core, sitting directly upstream of the instruction decoder. It accepts one fetch, load or store request at a time from the control FSM and runs it on a single-port bus with a `waitrequest` handshake. For fetches it writes the instruction register that drives the decoder's `Instr` input. For loads it fills the memory data register with the aligned, extended byte, half or word.

## Interface
Parameters:
- `ADDR_W`, default 32: byte-address width.
- `RESET_INSTR`, default 32'h0000_0000: reset value of `instr`.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: control requests an access.
- `req_ready` out 1: unit idle and able to accept.
- `req_kind` in 2: FETCH=0, LOAD=1, STORE=2; 3 is reserved and is treated as FETCH.
- `req_size` in 2: BYTE=0, HALF=1, WORD=2; 3 is treated as WORD; FETCH is always WORD.
- `req_signed` in 1: sign-extend loads (LB=1, LBU=0).
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data, right-justified.
- `done` out 1: one-cycle pulse when the access completes.
- `err` out 1: valid with `done`; 1 means the address was misaligned.
- `instr` out 32: instruction register.
- `mdr` out 32: memory data register.
- `address` out ADDR_W: word-aligned bus address; bits [1:0] are always 0.
- `read` out 1: bus read strobe.
- `write` out 1: bus write strobe.
- `byteenable` out 4: bus byte lanes.
- `writedata` out 32: bus write data.
- `readdata` in 32: bus read data.
- `waitrequest` in 1: bus stall.

## Operation
State machine, held in a registered state:
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`: latch kind, size, signed, addr[1:0] and wdata.
  - Misaligned request (HALF with addr[0]=1, or WORD/FETCH with addr[1:0]≠0): go to RESP with err=1 and start no bus cycle.
  - Otherwise: go to BUS, and drive `address`, `byteenable`, `writedata` and the strobe from the next cycle.
- **BUS**
  - Assert `read` (FETCH/LOAD) or `write` (STORE).
  - Hold all bus outputs stable while `waitrequest`=1.
  - On the edge where `waitrequest`=0:
    - FETCH writes `readdata` to `instr`.
    - LOAD writes the aligned/extended value to `mdr`.
  - Then go to RESP.
- **RESP**
  - `done`=1, strobes 0.
  - Go to IDLE.

Lane rules (little-endian lanes, k=addr[1:0]):
- Byte k occupies lanes [8k+7:8k].
- `byteenable`:
  - BYTE: 4'b0001<<k.
  - HALF: 4'b0011<<k.
  - WORD/FETCH: 4'hF.
  - Reads drive the same enables as writes.
- `writedata`:
  - BYTE: wdata[7:0] replicated ×4.
  - HALF: wdata[15:0] replicated ×2.
  - WORD: wdata.
- `mdr`:
  - Selected lane(s), right-justified.
  - Zero- or sign-extended per `req_signed`.
  - WORD ignores `req_signed`.

Other rules:
- `instr` and `mdr` hold their value until overwritten by a later FETCH or LOAD respectively.
- STORE and errored requests leave both unchanged.
- `req_ready` is combinational from state (=1 only in IDLE); `req_valid` in other states is ignored.

## Timing
- Accept edge = edge E.
- Minimum latency:
  - Strobe during cycle E+1; data captured at edge E+2; `done` high in cycle E+2.
  - With N waitrequest cycles: `done` in cycle E+2+N.
  - Next request can be accepted at edge E+3+N.
- Error path: `done`/`err` high in cycle E+1, no bus strobe ever.
- Bus timing: `address`, `byteenable` and `writedata` are registered, and are valid in the same cycle as the strobe.
- No combinational path from `waitrequest` or `readdata` to any output.
- Reset values (asynchronous, immediate on `rst_n` fall):
  - state=IDLE
  - `read`=`write`=0
  - `address`=0, `byteenable`=0, `writedata`=0
  - `instr`=RESET_INSTR, `mdr`=0
  - `done`=`err`=0
  - `req_ready`=1
- Reset mid-BUS drops the strobe in the same cycle; the access is abandoned and no capture occurs.
- `waitrequest` is don't-care outside BUS.

## Structure
- Package `mem_access_pkg`: `req_kind_t`, `req_size_t`, `mau_state_t` (IDLE, BUS, RESP), and the lane/enable constants.
- Sub-module `lane_align` (combinational):
  - Inputs: size, signed, offset, readdata, wdata.
  - Outputs: byteenable, writedata, load value.
- The top module holds the FSM and registers.

## Test plan
- FETCH addr 0x0000_0010, `waitrequest`=0, `readdata`=0x2409_0005 → `read` only in E+1, `address`=0x10, `byteenable`=4'hF, `instr`=0x2409_0005 and `done` in E+2, `mdr` unchanged.
- LOAD BYTE signed addr 0x...03, `readdata`=0x80FF_FF7F → `byteenable`=4'b1000, `mdr`=0xFFFF_FF80; same with signed=0 → `mdr`=0x0000_0080.
- STORE HALF addr 0x...02, wdata=0x1234_ABCD, `waitrequest` high 3 cycles → `write` held 4 cycles with `byteenable`=4'b1100, `writedata`=0xABCD_ABCD, `done` at E+5.
- LOAD WORD addr 0x...06 → `err`=1 and `done` in E+1, `read`/`write` never asserted, `mdr` unchanged.
- Back-to-back: `req_valid` held high across two requests → second accepted only when `req_ready`=1 in IDLE; requests asserted during BUS/RESP are ignored.
- Deassert `rst_n` during BUS with `waitrequest`=1 → `read`=0 in the same cycle, all outputs at reset values, and a fresh FETCH completes normally afterwards.

Source files
------------

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared types, lane constants and request helpers for mem_access_unit
package mem_access_pkg;

  typedef enum logic [1:0] {
    KIND_FETCH = 2'd0,
    KIND_LOAD  = 2'd1,
    KIND_STORE = 2'd2,
    KIND_RSVD  = 2'd3
  } req_kind_t;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } req_size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } mau_state_t;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Fetches are always full words; the reserved size code also means word.
  function automatic req_size_t norm_size(req_kind_t kind, req_size_t size);
    if (kind == KIND_FETCH || size == SIZE_RSVD) return SIZE_WORD;
    return size;
  endfunction

  function automatic logic misaligned(req_size_t size, logic [1:0] off);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return off[0];
      default:   return (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response and memory bus interfaces for mem_access_unit
// mau_req_if: control FSM side (req_* in, req_ready/done/err/instr/mdr out of the unit).
// mau_bus_if: single-port memory bus with waitrequest stall.
interface mau_req_if #(parameter int unsigned ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_kind;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              done;
  logic              err;
  logic [31:0]       instr;
  logic [31:0]       mdr;

  modport master (
    output req_valid, req_kind, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, done, err, instr, mdr
  );
  modport slave (
    input  req_valid, req_kind, req_size, req_signed, req_addr, req_wdata,
    output req_ready, done, err, instr, mdr
  );
endinterface

interface mau_bus_if #(parameter int unsigned ADDR_W = 32);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [3:0]        byteenable;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              waitrequest;

  modport master (
    output address, read, write, byteenable, writedata,
    input  readdata, waitrequest
  );
  modport slave (
    input  address, read, write, byteenable, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// rtl/mem_access_unit_lane_align.sv - combinational byte-lane steering for loads and stores
// Inputs: size, sgn (sign-extend), offset (addr[1:0]), readdata, wdata.
// Outputs: byteenable, writedata (replicated store data), load_value (aligned, extended).
module lane_align
  import mem_access_pkg::*;
(
  input  req_size_t   size,
  input  logic        sgn,
  input  logic [1:0]  offset,
  input  logic [31:0] readdata,
  input  logic [31:0] wdata,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic [31:0] load_value
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    rd_byte    = readdata[{offset, 3'b000} +: 8];
    // Halves are only ever aligned, so offset[1] alone picks the lane pair.
    rd_half    = readdata[{offset[1], 4'b0000} +: 16];
    byteenable = BE_WORD;
    writedata  = wdata;
    load_value = readdata;
    case (size)
      SIZE_BYTE: begin
        byteenable = BE_BYTE << offset;
        writedata  = {4{wdata[7:0]}};
        load_value = {{24{sgn & rd_byte[7]}}, rd_byte};
      end
      SIZE_HALF: begin
        byteenable = BE_HALF << {offset[1], 1'b0};
        writedata  = {2{wdata[15:0]}};
        load_value = {{16{sgn & rd_half[15]}}, rd_half};
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - multicycle MIPS memory access stage (fetch/load/store over a waitrequest bus)
// Ports: clk, rst_n (async active-low), req (mau_req_if.slave: request in, done/err/instr/mdr out),
// bus (mau_bus_if.master: registered address/byteenable/writedata, read/write strobes).
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
  input logic       clk,
  input logic       rst_n,
  mau_req_if.slave  req,
  mau_bus_if.master bus
);

  mau_state_t        state, state_nxt;
  req_kind_t         kind_q, in_kind;
  req_size_t         size_q, in_size, la_size;
  logic              sgn_q, err_q, in_mis;
  logic [1:0]        off_q, la_off;
  logic [ADDR_W-1:0] address_q;
  logic [3:0]        be_q, la_be;
  logic [31:0]       wd_q, la_wd, la_load, instr_q, mdr_q;
  logic              accept, bus_done;

  always_comb begin
    in_kind = (req.req_kind == 2'd3) ? KIND_FETCH : req_kind_t'(req.req_kind);
    in_size = norm_size(in_kind, req_size_t'(req.req_size));
    in_mis  = misaligned(in_size, req.req_addr[1:0]);
  end

  assign accept   = (state == ST_IDLE) && req.req_valid;
  assign bus_done = (state == ST_BUS) && !bus.waitrequest;

  // One aligner serves both phases: in IDLE it shapes the incoming store/enables,
  // afterwards it extracts the load value from the latched size/offset.
  assign la_size = (state == ST_IDLE) ? in_size : size_q;
  assign la_off  = (state == ST_IDLE) ? req.req_addr[1:0] : off_q;

  lane_align u_lane_align (
    .size       (la_size),
    .sgn        (sgn_q),
    .offset     (la_off),
    .readdata   (bus.readdata),
    .wdata      (req.req_wdata),
    .byteenable (la_be),
    .writedata  (la_wd),
    .load_value (la_load)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req.req_valid) state_nxt = in_mis ? ST_RESP : ST_BUS;
      ST_BUS:  if (!bus.waitrequest) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind_q    <= KIND_FETCH;
      size_q    <= SIZE_WORD;
      sgn_q     <= 1'b0;
      off_q     <= 2'b00;
      err_q     <= 1'b0;
      address_q <= '0;
      be_q      <= 4'b0000;
      wd_q      <= 32'h0;
      instr_q   <= RESET_INSTR;
      mdr_q     <= 32'h0;
    end else begin
      if (accept) begin
        kind_q <= in_kind;
        size_q <= in_size;
        sgn_q  <= req.req_signed;
        off_q  <= req.req_addr[1:0];
        err_q  <= in_mis;
        if (!in_mis) begin
          address_q <= {req.req_addr[ADDR_W-1:2], 2'b00};
          be_q      <= la_be;
          wd_q      <= la_wd;
        end
      end
      if (bus_done) begin
        if (kind_q == KIND_FETCH)     instr_q <= bus.readdata;
        else if (kind_q == KIND_LOAD) mdr_q   <= la_load;
      end
    end
  end

  // Strobes decode from registered state only, so reset drops them at once
  // and waitrequest never reaches an output combinationally.
  assign bus.read       = (state == ST_BUS) && (kind_q != KIND_STORE);
  assign bus.write      = (state == ST_BUS) && (kind_q == KIND_STORE);
  assign bus.address    = address_q;
  assign bus.byteenable = be_q;
  assign bus.writedata  = wd_q;

  assign req.req_ready = (state == ST_IDLE);
  assign req.done      = (state == ST_RESP);
  assign req.err       = (state == ST_RESP) && err_q;
  assign req.instr     = instr_q;
  assign req.mdr       = mdr_q;

endmodule
